// File: rtl/radix_entry_encoder_pkg.sv
// Shared definitions for the radix entry path: radix codes, entry FSM states
// and radix helpers, also reused by the display path's mode FSM.
package radix_entry_encoder_pkg;

  localparam logic [1:0] RADIX_OCT = 2'b00;
  localparam logic [1:0] RADIX_DEC = 2'b01;
  localparam logic [1:0] RADIX_HEX = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_ERR   = 2'd3
  } entry_state_t;

  // The unused code 2'b11 is folded back to octal wherever a radix is consumed.
  function automatic logic [1:0] radix_sanitize(input logic [1:0] radix);
    logic [1:0] result;
    result = (radix == 2'b11) ? RADIX_OCT : radix;
    return result;
  endfunction

  function automatic logic [4:0] radix_base(input logic [1:0] radix);
    logic [4:0] base;
    case (radix)
      RADIX_DEC: base = 5'd10;
      RADIX_HEX: base = 5'd16;
      default:   base = 5'd8;
    endcase
    return base;
  endfunction

  function automatic logic [1:0] radix_next(input logic [1:0] radix);
    logic [1:0] result;
    case (radix)
      RADIX_OCT: result = RADIX_DEC;
      RADIX_DEC: result = RADIX_HEX;
      default:   result = RADIX_OCT;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/radix_entry_encoder_if.sv
// Switch/button inputs and entered-value outputs of the radix entry encoder.
interface radix_entry_encoder_if;

  logic [3:0] digit_in;
  logic       digit_stb;
  logic       enter;
  logic       clear;
  logic       mode_btn;
  logic [3:0] value;
  logic       value_valid;
  logic       error;
  logic [1:0] radix;
  logic [1:0] digit_count;

  modport master (
    output digit_in, digit_stb, enter, clear, mode_btn,
    input  value, value_valid, error, radix, digit_count
  );

  modport slave (
    input  digit_in, digit_stb, enter, clear, mode_btn,
    output value, value_valid, error, radix, digit_count
  );

endinterface

// File: rtl/radix_entry_encoder_btn_edge_sync.sv
// Raw button conditioning: SYNC_STAGES-deep synchronizer followed by a
// registered rising-edge detector that emits a single-clock pulse.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The pulse is registered so a press is acted on one cycle after the
  // synchronized level first goes high; holding the button gives one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/radix_entry_encoder.sv
// Keypad-style entry of up to two digits in octal/decimal/hex, converted to
// a 4-bit binary value for the display system's input bus.
module radix_entry_encoder
  import radix_entry_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  radix_entry_encoder_if.slave  bus
);

  logic digit_p;
  logic enter_p;
  logic clear_p;
  logic mode_p;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_digit_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.digit_stb),
    .pulse (digit_p)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.enter),
    .pulse (enter_p)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.clear),
    .pulse (clear_p)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.mode_btn),
    .pulse (mode_p)
  );

  entry_state_t state_q, state_d;
  logic [7:0]   acc_q, acc_d;
  logic [3:0]   value_q, value_d;
  logic         valid_q, valid_d;
  logic [1:0]   radix_q, radix_d;

  logic [1:0]   radix_cur;
  logic [4:0]   base;
  logic         digit_ok;
  logic [7:0]   acc_mac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      radix_q <= RADIX_OCT;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      valid_q <= valid_d;
      radix_q <= radix_d;
    end
  end

  // acc never exceeds 15 before the second digit, so acc*base+digit fits in 8 bits.
  always_comb begin
    radix_cur = radix_sanitize(radix_q);
    base      = radix_base(radix_cur);
    digit_ok  = ({1'b0, bus.digit_in} < base);
    acc_mac   = acc_q * {3'b000, base} + {4'b0000, bus.digit_in};
  end

  // Only the highest-priority pulse acts: clear > mode > enter > digit.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    value_d = value_q;
    valid_d = 1'b0;
    radix_d = radix_cur;

    if (clear_p) begin
      acc_d   = '0;
      state_d = ST_EMPTY;
    end else if (mode_p) begin
      radix_d = radix_next(radix_cur);
      acc_d   = '0;
      state_d = ST_EMPTY;
    end else if (enter_p) begin
      if (state_q == ST_ONE || state_q == ST_TWO) begin
        if (acc_q <= 8'd15) begin
          value_d = acc_q[3:0];
          valid_d = 1'b1;
          acc_d   = '0;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ERR;
        end
      end
    end else if (digit_p) begin
      case (state_q)
        ST_EMPTY: begin
          if (digit_ok) begin
            acc_d   = {4'b0000, bus.digit_in};
            state_d = ST_ONE;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_ONE: begin
          if (digit_ok) begin
            acc_d   = acc_mac;
            state_d = ST_TWO;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_TWO:  state_d = ST_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bus.value       = value_q;
    bus.value_valid = valid_q;
    bus.radix       = radix_cur;
    bus.error       = (state_q == ST_ERR);
    case (state_q)
      ST_ONE:  bus.digit_count = 2'd1;
      ST_TWO:  bus.digit_count = 2'd2;
      default: bus.digit_count = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_radix_entry_encoder.sv
// Directed and randomized button sequences for radix_entry_encoder, checked
// against an event-level model that keeps the entered digits in a queue.
module tb_radix_entry_encoder;

  localparam int SYNC_STAGES = 2;
  localparam logic [3:0] B_DIGIT = 4'b0001;
  localparam logic [3:0] B_ENTER = 4'b0010;
  localparam logic [3:0] B_CLEAR = 4'b0100;
  localparam logic [3:0] B_MODE  = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  radix_entry_encoder_if bus ();

  radix_entry_encoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed value_valid pulses and any pulse lasting more than one cycle.
  int pulse_cnt  = 0;
  int long_pulse = 0;
  bit valid_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.value_valid === 1'b1) begin
      pulse_cnt++;
      if (valid_prev) long_pulse++;
    end
    valid_prev = (bus.value_valid === 1'b1);
  end

  int m_radix;
  int m_digits[$];
  bit m_err;
  int m_value;
  int m_pulses;

  function automatic int base_of(input int r);
    return (r == 0) ? 8 : ((r == 1) ? 10 : 16);
  endfunction

  task automatic modelReset();
    m_radix = 0;
    m_digits.delete();
    m_err    = 1'b0;
    m_value  = 0;
    m_pulses = pulse_cnt;
  endtask

  task automatic modelEvent(input logic [3:0] mask, input int d);
    int num;
    if (mask[2]) begin
      m_digits.delete();
      m_err = 1'b0;
    end else if (mask[3]) begin
      m_radix = (m_radix + 1) % 3;
      m_digits.delete();
      m_err = 1'b0;
    end else if (mask[1]) begin
      if (!m_err && m_digits.size() > 0) begin
        num = 0;
        foreach (m_digits[i]) num = num * base_of(m_radix) + m_digits[i];
        if (num <= 15) begin
          m_value = num;
          m_pulses++;
        end else begin
          m_err = 1'b1;
        end
        m_digits.delete();
      end
    end else if (mask[0]) begin
      if (!m_err) begin
        if (d >= base_of(m_radix) || m_digits.size() >= 2) begin
          m_err = 1'b1;
          m_digits.delete();
        end else begin
          m_digits.push_back(d);
        end
      end
    end
  endtask

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setButtons(input logic [3:0] mask);
    bus.digit_stb = mask[0];
    bus.enter     = mask[1];
    bus.clear     = mask[2];
    bus.mode_btn  = mask[3];
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int d, input int hold = 2);
    @(negedge clk);
    bus.digit_in = d[3:0];
    setButtons(mask);
    repeat (hold) @(negedge clk);
    setButtons(4'b0000);
    repeat (5) @(negedge clk);
    modelEvent(mask, d);
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".value"}, {28'd0, bus.value}, m_value);
    expectEq({tag, ".error"}, {31'd0, bus.error}, {31'd0, m_err});
    expectEq({tag, ".radix"}, {30'd0, bus.radix}, m_radix);
    expectEq({tag, ".count"}, {30'd0, bus.digit_count}, m_err ? 0 : m_digits.size());
    expectEq({tag, ".pulses"}, pulse_cnt, m_pulses);
    expectEq({tag, ".pulse_width"}, long_pulse, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] mask;
    int         r;

    bus.digit_in = 4'd0;
    setButtons(4'b0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("reset");
    expectEq("reset.valid", {31'd0, bus.value_valid}, 0);

    // First octal digit with exact latency: rises before edge N, acts at N+3.
    @(negedge clk);
    bus.digit_in  = 4'd1;
    bus.digit_stb = 1'b1;
    repeat (3) @(negedge clk);
    expectEq("latency.before", {30'd0, bus.digit_count}, 0);
    @(negedge clk);
    expectEq("latency.at", {30'd0, bus.digit_count}, 1);
    bus.digit_stb = 1'b0;
    repeat (5) @(negedge clk);
    modelEvent(B_DIGIT, 1);
    checkOutput("oct_d1");

    applyStimulus(B_DIGIT, 7);
    checkOutput("oct_d7");
    expectEq("oct_d7.count2", {30'd0, bus.digit_count}, 2);
    applyStimulus(B_ENTER, 0);
    checkOutput("oct_enter");
    expectEq("oct_enter.value_f", {28'd0, bus.value}, 15);

    applyStimulus(B_MODE, 0);
    checkOutput("mode_dec");
    applyStimulus(B_DIGIT, 1);
    applyStimulus(B_DIGIT, 3);
    applyStimulus(B_ENTER, 0);
    checkOutput("dec_13");
    expectEq("dec_13.value", {28'd0, bus.value}, 13);
    applyStimulus(B_DIGIT, 1);
    applyStimulus(B_DIGIT, 6);
    applyStimulus(B_ENTER, 0);
    checkOutput("dec_16_err");
    expectEq("dec_16_err.error", {31'd0, bus.error}, 1);

    applyStimulus(B_MODE, 0);
    applyStimulus(B_MODE, 0);
    applyStimulus(B_DIGIT, 9);
    checkOutput("oct_9_err");
    applyStimulus(B_DIGIT, 2);
    applyStimulus(B_ENTER, 0);
    checkOutput("err_ignores");
    applyStimulus(B_CLEAR, 0);
    checkOutput("err_clear");
    expectEq("err_clear.radix", {30'd0, bus.radix}, 0);

    applyStimulus(B_MODE, 0);
    applyStimulus(B_MODE, 0);
    applyStimulus(B_DIGIT, 10);
    applyStimulus(B_ENTER, 0);
    checkOutput("hex_a");
    expectEq("hex_a.value", {28'd0, bus.value}, 10);
    applyStimulus(B_DIGIT, 0);
    applyStimulus(B_DIGIT, 11);
    applyStimulus(B_ENTER, 0);
    checkOutput("hex_0b");
    applyStimulus(B_DIGIT, 1);
    applyStimulus(B_DIGIT, 0);
    applyStimulus(B_ENTER, 0);
    checkOutput("hex_10_err");
    applyStimulus(B_MODE, 0);
    checkOutput("hex_wrap");
    expectEq("hex_wrap.radix", {30'd0, bus.radix}, 0);

    applyStimulus(B_DIGIT, 5, 20);
    checkOutput("hold");
    expectEq("hold.count", {30'd0, bus.digit_count}, 1);
    applyStimulus(B_DIGIT, 2);
    applyStimulus(B_DIGIT, 3);
    checkOutput("third_digit");
    expectEq("third_digit.error", {31'd0, bus.error}, 1);
    applyStimulus(B_CLEAR, 0);

    applyStimulus(B_DIGIT, 4);
    applyStimulus(B_ENTER | B_CLEAR, 0);
    checkOutput("enter_clear");

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      if (r < 8)        mask = B_DIGIT;
      else if (r < 11)  mask = B_ENTER;
      else if (r == 11) mask = B_CLEAR;
      else if (r == 12) mask = B_MODE;
      else              mask = 4'($urandom_range(1, 15));
      applyStimulus(mask, $urandom_range(0, 15));
      checkOutput($sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a decimal entry with a nonzero value.
    applyStimulus(B_CLEAR, 0);
    while (m_radix != 1) applyStimulus(B_MODE, 0);
    applyStimulus(B_DIGIT, 9);
    applyStimulus(B_ENTER, 0);
    applyStimulus(B_DIGIT, 3);
    checkOutput("pre_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expectEq("async_rst.value", {28'd0, bus.value}, 0);
    expectEq("async_rst.valid", {31'd0, bus.value_valid}, 0);
    expectEq("async_rst.error", {31'd0, bus.error}, 0);
    expectEq("async_rst.radix", {30'd0, bus.radix}, 0);
    expectEq("async_rst.count", {30'd0, bus.digit_count}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(B_DIGIT, 6);
    checkOutput("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
